// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side DMA engine for the wishbone BRAM slave.
// Walks a block of RAM words from a base address and presents each word on a
// valid/ready stream. The RAM read port has a 2-stage enabled pipeline, tracked
// here by v1/l1 (address captured) and v2/l2 (data present).
module bram_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [31:0]           bram_read_address,
  input  logic [DATA_WIDTH-1:0] bram_data_out,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic                  v1;
  logic                  v2;
  logic                  l1;
  logic                  l2;
  logic                  stall;
  logic                  handshake;
  logic                  accept_start;
  logic                  base_addr_unused;

  // Only the low address bits index the RAM.
  assign base_addr_unused = ^base_addr[31:ADDR_WIDTH];

  // Hold the pipeline whenever the presented word has not been taken yet.
  assign stall        = v2 & ~m_ready;
  assign handshake    = v2 & m_ready;
  assign accept_start = (state == S_IDLE) & start & ~abort;

  assign m_data            = bram_data_out;
  assign m_valid           = v2;
  assign m_last            = l2;
  assign bram_read_address = 32'(addr);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides everything and drops a coincident start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_start) begin
          state_nxt = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bram_en && (remaining == CNT_WIDTH'(1))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (handshake && l2) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
    end
  end

  // Outputs decoded from state; bram_en also follows m_ready combinationally.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    bram_en = 1'b0;
    case (state)
      S_ISSUE, S_DRAIN: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default:          busy = 1'b0;
    endcase
    bram_en = busy & ~stall;
  end

  // Address/remaining counters and RAM pipeline tracking bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
    end else if (abort) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
    end else begin
      if (accept_start && (count != '0)) begin
        addr      <= base_addr[ADDR_WIDTH-1:0];
        remaining <= count;
      end
      if (bram_en) begin
        v2 <= v1;
        l2 <= l1;
        if (state == S_ISSUE) begin
          v1        <= 1'b1;
          l1        <= (remaining == CNT_WIDTH'(1));
          addr      <= addr + ADDR_WIDTH'(1);
          remaining <= remaining - CNT_WIDTH'(1);
        end else begin
          v1 <= 1'b0;
          l1 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: behavioural BRAM plus a queue-based
// reference of the words each transfer must deliver.
module tb_bram_stream_reader;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [CW-1:0] count = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic          bram_en;
  logic [31:0]   bram_read_address;
  logic [DW-1:0] bram_data_out;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .count             (count),
    .abort             (abort),
    .busy              (busy),
    .done              (done),
    .bram_en           (bram_en),
    .bram_read_address (bram_read_address),
    .bram_data_out     (bram_data_out),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: address captured on one enabled edge, data on the next.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_addr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q    <= '0;
      bram_data_out <= '0;
    end else if (bram_en) begin
      ram_addr_q    <= bram_read_address[AW-1:0];
      bram_data_out <= mem[ram_addr_q];
    end
  end

  int            checks = 0;
  int            errors = 0;
  int            tick_no = 0;
  int            start_tick = 0;
  int            first_valid_tick = -1;
  int            done_tick = -1;
  int            hs_count = 0;
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [31:0]   prev_addr;
  logic [31:0]   cmd_base = '0;
  logic [CW-1:0] cmd_count = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, update the model.
  task automatic tick(input logic st, input logic ab, input logic rdy, input logic r);
    logic          hs;
    logic          hs_last;
    logic          idle;
    logic [DW-1:0] exp_w;
    logic [AW-1:0] a;
    @(negedge clk);
    start     = st;
    abort     = ab;
    m_ready   = rdy;
    rst       = r;
    base_addr = cmd_base;
    count     = cmd_count;
    #1;
    tick_no++;
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("addr_range", 32'(bram_read_address < 32'(DEPTH)), 32'(1));
    check("bram_en", 32'(bram_en), 32'(exp_busy && !(m_valid && !m_ready)));
    if (!exp_busy) check("valid_idle", 32'(m_valid), 32'(0));
    if (prev_stall) begin
      check("stall_valid", 32'(m_valid), 32'(1));
      check("stall_data", m_data, prev_data);
      check("stall_last", 32'(m_last), 32'(prev_last));
      check("stall_addr", bram_read_address, prev_addr);
    end
    if (m_valid && first_valid_tick < 0) first_valid_tick = tick_no;
    if (done) done_tick = tick_no;
    hs      = m_valid && m_ready;
    hs_last = 1'b0;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(m_valid), 32'(0));
      end else begin
        exp_w   = exp_q.pop_front();
        hs_last = (exp_q.size() == 0);
        check("data", m_data, exp_w);
        check("last", 32'(m_last), 32'(hs_last));
        hs_count++;
      end
    end
    prev_stall = m_valid && !m_ready && !ab && !r;
    prev_data  = m_data;
    prev_last  = m_last;
    prev_addr  = bram_read_address;
    idle = !exp_busy && !exp_done;
    if (r || (ab && !idle)) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_q.delete();
    end else if (idle && st && !ab) begin
      start_tick       = tick_no;
      first_valid_tick = -1;
      done_tick        = -1;
      hs_count         = 0;
      if (count == '0) begin
        exp_done = 1'b1;
      end else begin
        exp_busy = 1'b1;
        for (int i = 0; i < int'(count); i++) begin
          a = base_addr[AW-1:0] + AW'(i);
          exp_q.push_back(mem[a]);
        end
      end
    end else if (exp_busy && hs_last) begin
      exp_busy = 1'b0;
      exp_done = 1'b1;
    end else begin
      exp_done = 1'b0;
    end
  endtask

  // mode 0: ready always high; 1: random ready, stray starts, rare aborts; 2: ready 1,0,0 repeating.
  task automatic run_to_idle(input int mode, input int budget);
    int   cyc;
    logic rdy;
    logic st;
    logic ab;
    cyc = 0;
    while ((exp_busy || exp_done) && cyc < budget) begin
      st = 1'b0;
      ab = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = ((cyc % 3) == 0);
      endcase
      if (mode == 1) begin
        st = ($urandom_range(0, 15) == 0);
        ab = ($urandom_range(0, 149) == 0);
        if (st) begin
          cmd_base  = $urandom;
          cmd_count = CW'($urandom);
        end
      end
      tick(st, ab, rdy, 1'b0);
      cyc++;
    end
    if (cyc >= budget) check("timeout", 32'(cyc), 32'(budget - 1));
  endtask

  task automatic launch(input logic [31:0] b, input logic [CW-1:0] c);
    cmd_base  = b;
    cmd_count = c;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Reset state.
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_last", 32'(m_last), 32'(0));
    check("rst_addr", bram_read_address, 32'(0));
    check("rst_data", m_data, 32'(0));

    // Basic transfer with ready held high: latency and length.
    launch(32'd4, CW'(4));
    run_to_idle(0, 50);
    check("a_words", 32'(hs_count), 32'(4));
    check("a_first_valid_lat", 32'(first_valid_tick - start_tick), 32'(3));
    check("a_done_lat", 32'(done_tick - start_tick), 32'(4 + 3));

    // Zero-length command: done only.
    launch(32'd9, CW'(0));
    run_to_idle(0, 10);
    check("z_words", 32'(hs_count), 32'(0));
    check("z_done_lat", 32'(done_tick - start_tick), 32'(1));
    check("z_first_valid", 32'(first_valid_tick), 32'(-1));

    // Address wrap at the top of the RAM.
    launch(32'd1022, CW'(4));
    run_to_idle(0, 50);
    check("w_words", 32'(hs_count), 32'(4));
    check("w_done_lat", 32'(done_tick - start_tick), 32'(4 + 3));

    // Backpressure pattern.
    launch(32'd100, CW'(8));
    run_to_idle(2, 200);
    check("bp_words", 32'(hs_count), 32'(8));

    // Abort coinciding with the third handshake, then a fresh start.
    launch(32'd200, CW'(10));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check("ab_words", 32'(hs_count), 32'(3));
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("ab_no_done", 32'(done_tick), 32'(-1));
    launch(32'd500, CW'(3));
    run_to_idle(0, 50);
    check("ab_restart_words", 32'(hs_count), 32'(3));

    // Start while busy is ignored.
    launch(32'd300, CW'(6));
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    cmd_base  = 32'd700;
    cmd_count = CW'(2);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    run_to_idle(0, 50);
    check("sb_words", 32'(hs_count), 32'(6));

    // Reset in the middle of a transfer.
    launch(32'd50, CW'(8));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("mr_valid", 32'(m_valid), 32'(0));
    check("mr_last", 32'(m_last), 32'(0));
    check("mr_busy", 32'(busy), 32'(0));
    check("mr_en", 32'(bram_en), 32'(0));
    check("mr_addr", bram_read_address, 32'(0));
    check("mr_data", m_data, 32'(0));

    // Full-depth transfer.
    launch($urandom, CW'(DEPTH));
    run_to_idle(0, 1100);
    check("full_words", 32'(hs_count), 32'(DEPTH));
    check("full_done_lat", 32'(done_tick - start_tick), 32'(DEPTH + 3));

    // Randomized transfers with random data, backpressure and aborts.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
      end
      launch($urandom, CW'($urandom_range(0, 40)));
      run_to_idle(1, 400);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
